// File: rtl/regfile_bypass.sv
// regfile_bypass: 31x WIDTH regs (r0 reads 0), bypassed read ports A/B, raw debug port dbg_sel/dbg_data, write_count and written_mask
module regfile_bypass #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ctrl_writeEnable,
  input  logic [4:0]           ctrl_writeReg,
  input  logic [WIDTH-1:0]     data_writeReg,
  input  logic [4:0]           ctrl_readRegA,
  input  logic [4:0]           ctrl_readRegB,
  output logic [WIDTH-1:0]     data_readRegA,
  output logic [WIDTH-1:0]     data_readRegB,
  input  logic [4:0]           dbg_sel,
  output logic [WIDTH-1:0]     dbg_data,
  output logic [CNT_WIDTH-1:0] write_count,
  output logic [31:0]          written_mask
);
  logic [31:1][WIDTH-1:0] regs;
  logic commit;
  assign commit = ctrl_writeEnable && ctrl_writeReg != 5'd0;
  function automatic logic [WIDTH-1:0] stored(input logic [4:0] idx);
    return idx == 5'd0 ? '0 : regs[idx];
  endfunction
  function automatic logic [WIDTH-1:0] bypassed(input logic [4:0] idx);
    return (commit && ctrl_writeReg == idx) ? data_writeReg : stored(idx);
  endfunction
  assign data_readRegA = bypassed(ctrl_readRegA);
  assign data_readRegB = bypassed(ctrl_readRegB);
  assign dbg_data = stored(dbg_sel);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '0;
      write_count <= '0;
      written_mask <= '0;
    end else if (commit) begin
      regs[ctrl_writeReg] <= data_writeReg;
      write_count <= write_count + CNT_WIDTH'(1);
      written_mask[ctrl_writeReg] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed scenarios plus randomized traffic checked against an array model
module tb_regfile_bypass;
  logic clock = 0, reset = 0, we = 0;
  logic [4:0] wr = 0, ra = 0, rb = 0, dsel = 0;
  logic [31:0] wd = 0;
  logic [31:0] da, db, dd, mask;
  logic [3:0] cnt;
  int checks = 0, passes = 0;
  logic [31:0] model [32];
  int count;
  logic [31:0] m_mask;
  always #5 clock = ~clock;
  regfile_bypass #(.WIDTH(32), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(da), .data_readRegB(db), .dbg_sel(dsel), .dbg_data(dd),
    .write_count(cnt), .written_mask(mask)
  );
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (we && wr == idx) return wd;
    return model[idx];
  endfunction
  task automatic model_reset();
    foreach (model[i]) model[i] = 32'd0;
    count = 0;
    m_mask = 32'd0;
  endtask
  task automatic tick();
    @(posedge clock);
    if (reset && we && wr != 0) begin
      model[wr] = wd;
      count = (count + 1) % 16;
      m_mask[wr] = 1'b1;
    end
    #1;
  endtask
  task automatic put(input logic e, input logic [4:0] r, input logic [31:0] d);
    we = e;
    wr = r;
    wd = d;
  endtask
  task automatic test_reset();
    reset = 0;
    model_reset();
    tick();
    tick();
    reset = 1;
    for (int i = 0; i < 6; i++) begin
      put(1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    put(0, 0, 0);
    ra = 3;
    rb = 9;
    #2;
    reset = 0;
    model_reset();
    #1;
    checks++; if (da !== 32'd0) $display("FAIL reset_a got %h want 0", da); else passes++;
    checks++; if (db !== 32'd0) $display("FAIL reset_b got %h want 0", db); else passes++;
    checks++; if (cnt !== 4'd0) $display("FAIL reset_count got %0d want 0", cnt); else passes++;
    checks++; if (mask !== 32'd0) $display("FAIL reset_mask got %h want 0", mask); else passes++;
    tick();
    reset = 1;
  endtask
  task automatic test_write_read();
    put(1, 3, 32'hDEADBEEF);
    tick();
    put(0, 0, 0);
    ra = 3;
    dsel = 3;
    #1;
    checks++; if (da !== 32'hDEADBEEF) $display("FAIL wr_read_a got %h want deadbeef", da); else passes++;
    checks++; if (dd !== 32'hDEADBEEF) $display("FAIL wr_read_dbg got %h want deadbeef", dd); else passes++;
    checks++; if (cnt !== 4'd1) $display("FAIL wr_read_count got %0d want 1", cnt); else passes++;
    checks++; if (mask !== 32'h8) $display("FAIL wr_read_mask got %h want 00000008", mask); else passes++;
  endtask
  task automatic test_r0();
    put(1, 0, 32'h12345678);
    ra = 0;
    rb = 0;
    dsel = 0;
    #1;
    checks++; if (da !== 32'd0) $display("FAIL r0_a got %h want 0", da); else passes++;
    checks++; if (db !== 32'd0) $display("FAIL r0_b got %h want 0", db); else passes++;
    tick();
    put(0, 0, 0);
    #1;
    checks++; if (dd !== 32'd0) $display("FAIL r0_dbg got %h want 0", dd); else passes++;
    checks++; if (cnt !== 4'(count)) $display("FAIL r0_count got %0d want %0d", cnt, count); else passes++;
    checks++; if (mask[0] !== 1'b0) $display("FAIL r0_mask0 got %b want 0", mask[0]); else passes++;
  endtask
  task automatic test_bypass();
    put(1, 5, 32'h11);
    tick();
    put(1, 5, 32'h22);
    ra = 5;
    rb = 5;
    dsel = 5;
    #1;
    checks++; if (da !== 32'h22) $display("FAIL byp_a got %h want 22", da); else passes++;
    checks++; if (db !== 32'h22) $display("FAIL byp_b got %h want 22", db); else passes++;
    checks++; if (dd !== 32'h11) $display("FAIL byp_dbg_before got %h want 11", dd); else passes++;
    tick();
    put(0, 0, 0);
    #1;
    checks++; if (dd !== 32'h22) $display("FAIL byp_dbg_after got %h want 22", dd); else passes++;
  endtask
  task automatic test_reset_mid();
    put(1, 7, 32'hAA);
    tick();
    put(1, 7, 32'hBB);
    ra = 7;
    dsel = 7;
    #2;
    reset = 0;
    model_reset();
    #1;
    checks++; if (da !== 32'hBB) $display("FAIL rmid_byp got %h want bb", da); else passes++;
    checks++; if (dd !== 32'd0) $display("FAIL rmid_dbg_low got %h want 0", dd); else passes++;
    tick();
    put(0, 0, 0);
    reset = 1;
    #1;
    checks++; if (dd !== 32'd0) $display("FAIL rmid_r7 got %h want 0", dd); else passes++;
    checks++; if (cnt !== 4'd0) $display("FAIL rmid_count got %0d want 0", cnt); else passes++;
    put(1, 7, 32'hCC);
    tick();
    put(0, 0, 0);
    #1;
    checks++; if (dd !== 32'hCC) $display("FAIL rmid_cc got %h want cc", dd); else passes++;
    checks++; if (cnt !== 4'd1) $display("FAIL rmid_count_cc got %0d want 1", cnt); else passes++;
  endtask
  task automatic test_wrap();
    logic [31:0] last;
    #2;
    reset = 0;
    model_reset();
    #2;
    reset = 1;
    last = 0;
    for (int i = 0; i < 17; i++) begin
      last = $urandom;
      put(1, 1, last);
      tick();
    end
    put(0, 0, 0);
    ra = 1;
    dsel = 1;
    #1;
    checks++; if (cnt !== 4'd1) $display("FAIL wrap_count got %0d want 1", cnt); else passes++;
    checks++; if (dd !== last) $display("FAIL wrap_r1 got %h want %h", dd, last); else passes++;
    checks++; if (da !== last) $display("FAIL wrap_a got %h want %h", da, last); else passes++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      put(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      dsel = 5'($urandom);
      #1;
      checks++; if (da !== exp_rd(ra)) $display("FAIL rnd_a idx %0d got %h want %h", ra, da, exp_rd(ra)); else passes++;
      checks++; if (db !== exp_rd(rb)) $display("FAIL rnd_b idx %0d got %h want %h", rb, db, exp_rd(rb)); else passes++;
      checks++; if (dd !== model[dsel]) $display("FAIL rnd_dbg idx %0d got %h want %h", dsel, dd, model[dsel]); else passes++;
      checks++; if (cnt !== 4'(count)) $display("FAIL rnd_count got %0d want %0d", cnt, count); else passes++;
      checks++; if (mask !== m_mask) $display("FAIL rnd_mask got %h want %h", mask, m_mask); else passes++;
      tick();
    end
    put(0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Architectural register file for the 5-stage pipelined processor: 32 general-purpose registers of 32 bits each, serving the `ctrl_readRegA`, `ctrl_readRegB`, `ctrl_writeReg`, `ctrl_writeEnable` and `data_writeReg` interface that `processor` drives. Register reads are combinational, with same-cycle write-to-read bypass, so that writeback and decode can share a cycle without a hazard. Writes commit on the rising clock edge. The block also keeps a write counter and a written-since-reset mask for bench visibility.

## Interface
Parameters:
- `WIDTH`, default 32: data width of each register.
- `CNT_WIDTH`, default 16: width of the write counter.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ctrl_writeEnable`  in  1: write strobe, sampled at the rising edge.
- `ctrl_writeReg`  in  5: destination register index.
- `data_writeReg`  in  WIDTH: write data.
- `ctrl_readRegA`  in  5: read port A index.
- `ctrl_readRegB`  in  5: read port B index.
- `data_readRegA`  out  WIDTH: read port A data (combinational).
- `data_readRegB`  out  WIDTH: read port B data (combinational).
- `dbg_sel`  in  5: debug read index; no bypass on this port.
- `dbg_data`  out  WIDTH: stored contents of register `dbg_sel`.
- `write_count`  out  CNT_WIDTH: number of committed writes since reset.
- `written_mask`  out  32: bit i is 1 if register i has been written since reset.

## Operation
- Storage is registers 1–31. Register 0 has no storage. Every read of index 0, on any port, returns 0.
- **Commit.** A write commits when, at a rising edge, `reset` is 1, `ctrl_writeEnable` is 1 and `ctrl_writeReg` is not 0. At that edge:
  - reg[`ctrl_writeReg`] takes `data_writeReg`.
  - `write_count` increments.
  - `written_mask[ctrl_writeReg]` is set.
- **Write to r0.** A write with `ctrl_writeEnable` = 1 and `ctrl_writeReg` = 0 is discarded entirely: no storage change, no count increment, and `written_mask[0]` stays 0 permanently.
- **Bypass.** For port X in {A, B}: if `ctrl_writeEnable` = 1, `ctrl_writeReg` = `ctrl_readRegX` and `ctrl_readRegX` is not 0, then `data_readRegX` = `data_writeReg`. Otherwise `data_readRegX` = the stored value.
  - Both ports bypass independently, including the case A = B = write index.
- **Debug port.** `dbg_data` always returns stored contents with no bypass. It therefore shows a new value only after the commit edge.
- **Write counter.** `write_count` wraps modulo 2^CNT_WIDTH: from all-ones it returns to 0 with no sticky flag. `written_mask` bits only ever set; only reset clears them.
- **Undefined indices.** X or Z on a read index yields X on that data output. X or Z on `ctrl_writeEnable` must not corrupt any register other than the addressed one; the bench does not check this case.

## Timing
- **Reset values** while `reset` = 0: all registers 0, `write_count` = 0, `written_mask` = 0. Read outputs then reflect zeros, except where a bypass is active.
- Reset acts immediately on assertion; it does not wait for a clock edge.
- **Reset mid-operation.** A write presented at a rising edge while `reset` = 0 is discarded. The first possible commit is the first rising edge with `reset` = 1.
- Deasserting `reset` close to a rising edge is the integrator's responsibility; no synchronizer is included.
- **Read latency:** 0 cycles, combinational from the index inputs and write-port inputs.
- **Write latency:** the stored value is visible on the non-bypassed path and on `dbg_data` from the rising edge at which it commits. It is visible on the bypassed read paths in the cycle before that edge.
- **Back-to-back writes** to the same register: the last committed write wins, and each commit increments `write_count`.

## Test plan
- **Reset state.** Assert `reset` = 0 mid-cycle with no clock edge. Required: `data_readRegA`/`B` = 0, `write_count` = 0, `written_mask` = 0 immediately.
- **Write then read.** Write 0xDEADBEEF to r3. At the next cycle, with `ctrl_writeEnable` = 0 and readRegA = 3, required:
  - `data_readRegA` = 0xDEADBEEF, `dbg_data`(3) = 0xDEADBEEF.
  - `write_count` = 1, `written_mask` = 0x00000008.
- **r0 protection.** Write 0x12345678 to r0. Required: reads of r0 on A, B and debug = 0, `write_count` unchanged, `written_mask[0]` = 0.
- **Bypass.** r5 holds 0x11. Present a write of 0x22 to r5 with readRegA = readRegB = 5. Required:
  - Before the edge: A = B = 0x22 and `dbg_data`(5) = 0x11.
  - After the edge: `dbg_data` = 0x22.
- **Reset mid-operation.** r7 holds 0xAA. Pull `reset` low between edges while a write of 0xBB to r7 is presented; hold it low across one edge, then release. Required: r7 = 0 and `write_count` = 0 after release. The next write of 0xCC commits with count = 1.
- **Counter wrap.** With `CNT_WIDTH` = 4, perform 17 writes to r1. Required: `write_count` = 1 and r1 = the last written value.
